// File: rtl/wormhole_port_allocator.sv
// wormhole_port_allocator
//
// Output-port allocator for one output of the 5-port NoC router (N, E, W, S, L).
// Five input ports compete for the output. A round-robin arbiter picks the winner.
// The output then stays locked to that input from the packet's head flit to its
// tail flit. Every flit transfer also needs a credit, meaning a free slot in the
// downstream input buffer.
//
// Handshake: req[i] plays the role of "valid" for input i. grant[i] plays the role
// of "ready". A flit moves from input i in exactly those cycles where grant[i] is
// high. grant is only raised while req[i] is high, so grant[i] alone marks the
// transfer. tail[i] is only meaningful in cycles where req[i] is high. When the
// transferring flit carries tail, the packet (and the lock) ends.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   req         per-input request (input has a flit for this output)
//   tail        per-input tail flag for the presented flit
//   credit_in   one-cycle pulse: downstream freed one buffer slot
//   grant       combinational one-hot/zero transfer strobe to the input FIFOs
//   xbar_sel    registered one-hot crossbar select for the owner; zero when idle
//   busy        registered: output locked to a packet (FSM is in LOCKED)
//   credits     registered current credit count
//   credit_err  sticky: credit returned while the counter was already full
module wormhole_port_allocator #(
    parameter int NPORTS  = 5,
    parameter int CREDITS = 4,
    localparam int CW     = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NPORTS-1:0] req,
    input  logic [NPORTS-1:0] tail,
    input  logic              credit_in,
    output logic [NPORTS-1:0] grant,
    output logic [NPORTS-1:0] xbar_sel,
    output logic              busy,
    output logic [CW-1:0]     credits,
    output logic              credit_err
);

    localparam int              OW        = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [CW-1:0]   CRED_MAX  = CW'(CREDITS);
    localparam logic [OW-1:0]   PTR_RESET = OW'(NPORTS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NPORTS-1:0] xbar_sel_q, xbar_sel_d;
    logic [CW-1:0]     credits_q, credits_d;
    logic              credit_err_q, credit_err_d;

    logic              arb_found;
    logic [OW-1:0]     arb_idx;
    logic              consume;
    logic              flit_done;

    // Round-robin search. It starts one past the previous owner, so the port
    // that just finished a packet has the lowest priority.
    always_comb begin : arbiter
        int            cand;
        logic [OW-1:0] cand_idx;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NPORTS; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NPORTS) begin
                cand = cand - NPORTS;
            end
            cand_idx = OW'(cand);
            if (!arb_found && req[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // xbar_sel_q is one-hot on the owner. Masking req with it gives
    // grant[owner] = req[owner] and zero for every other input.
    assign grant     = (state_q == LOCKED && credits_q != '0) ? (req & xbar_sel_q) : '0;
    assign consume   = |grant;
    assign flit_done = |(grant & tail);

    always_comb begin : next_state
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        xbar_sel_d   = xbar_sel_q;
        credits_d    = credits_q;
        credit_err_d = credit_err_q;

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d    = LOCKED;
                    owner_d    = arb_idx;
                    xbar_sel_d = NPORTS'(1) << arb_idx;
                end
            end
            LOCKED: begin
                // A bubble (owner drops req) just holds the lock. Only a
                // granted tail flit releases the output.
                if (flit_done) begin
                    state_d    = IDLE;
                    xbar_sel_d = '0;
                    rr_ptr_d   = owner_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Consume and return in the same cycle cancel out. Consume at zero cannot
        // happen because grant is gated by credits != 0.
        if (consume && !credit_in) begin
            credits_d = credits_q - CW'(1);
        end else if (!consume && credit_in) begin
            if (credits_q == CRED_MAX) begin
                credit_err_d = 1'b1;
            end else begin
                credits_d = credits_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= PTR_RESET;
            xbar_sel_q   <= '0;
            credits_q    <= CRED_MAX;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            xbar_sel_q   <= xbar_sel_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign xbar_sel   = xbar_sel_q;
    assign busy       = (state_q == LOCKED);
    assign credits    = credits_q;
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_wormhole_port_allocator.sv
// Testbench for wormhole_port_allocator.
// Each row of a stimulus table holds the inputs for one cycle and the outputs
// expected in that cycle. The inputs are driven at the falling edge. The expected
// output word goes into exp_q. It is popped and compared 1 ns later, after the
// combinational grant has settled. The per-cycle grant invariants are checked on
// the same sample.
module tb_wormhole_port_allocator;

    localparam int NPORTS = 5;
    localparam int CW     = 3;
    localparam int W      = NPORTS + NPORTS + 1 + CW + 1;

    typedef struct packed {
        logic [NPORTS-1:0] req;
        logic [NPORTS-1:0] tail;
        logic              cin;
        logic              rs;
        logic [W-1:0]      exp;
    } row_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NPORTS-1:0] req       = '0;
    logic [NPORTS-1:0] tail      = '0;
    logic              credit_in = 1'b0;
    logic [NPORTS-1:0] grant;
    logic [NPORTS-1:0] xbar_sel;
    logic              busy;
    logic [CW-1:0]     credits;
    logic              credit_err;

    wormhole_port_allocator #(.NPORTS(NPORTS), .CREDITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .tail       (tail),
        .credit_in  (credit_in),
        .grant      (grant),
        .xbar_sel   (xbar_sel),
        .busy       (busy),
        .credits    (credits),
        .credit_err (credit_err)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    row_t         rows[$];
    int           checks = 0;
    int           errors = 0;

    function automatic row_t mk(input logic [NPORTS-1:0] r, input logic [NPORTS-1:0] t,
                                input logic c, input logic rs_v,
                                input logic [NPORTS-1:0] g, input logic [NPORTS-1:0] x,
                                input logic b, input logic [CW-1:0] cr, input logic e);
        row_t rw;
        rw.req  = r;
        rw.tail = t;
        rw.cin  = c;
        rw.rs   = rs_v;
        rw.exp  = {g, x, b, cr, e};
        return rw;
    endfunction

    function automatic string fmt(input logic [W-1:0] v);
        return $sformatf("grant=%b xbar_sel=%b busy=%b credits=%0d credit_err=%b",
                         v[W-1 -: NPORTS], v[W-1-NPORTS -: NPORTS], v[CW+1], v[CW:1], v[0]);
    endfunction

    // ---------------- driver ----------------
    task automatic apply_row(input row_t rw);
        @(negedge clk);
        req       = rw.req;
        tail      = rw.tail;
        credit_in = rw.cin;
        rst       = rw.rs;
        exp_q.push_back(rw.exp);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [W-1:0] obs, expv;
        rst = 1'b1; req = '0; tail = '0; credit_in = 1'b0;
        repeat (2) @(negedge clk);
        rows.delete();
        rows.push_back(mk(5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 3'd4, 0));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            obs  = {grant, xbar_sel, busy, credits, credit_err};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset[%0d]: got %s, expected %s", i, fmt(obs), fmt(expv));
            end
        end
    endtask

    task automatic test_lock_and_credits();
        logic [W-1:0] obs, expv;
        rows.delete();
        rows.push_back(mk(5'b10001, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 3'd4, 0));
        rows.push_back(mk(5'b10001, 5'b00000, 0, 0, 5'b00001, 5'b00001, 1, 3'd4, 0));
        rows.push_back(mk(5'b10001, 5'b00000, 0, 0, 5'b00001, 5'b00001, 1, 3'd3, 0));
        rows.push_back(mk(5'b10001, 5'b00000, 0, 0, 5'b00001, 5'b00001, 1, 3'd2, 0));
        rows.push_back(mk(5'b10001, 5'b00000, 0, 0, 5'b00001, 5'b00001, 1, 3'd1, 0));
        rows.push_back(mk(5'b10001, 5'b00000, 0, 0, 5'b00000, 5'b00001, 1, 3'd0, 0));
        rows.push_back(mk(5'b10001, 5'b00000, 0, 0, 5'b00000, 5'b00001, 1, 3'd0, 0));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            obs  = {grant, xbar_sel, busy, credits, credit_err};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL lock_credits[%0d]: got %s, expected %s", i, fmt(obs), fmt(expv));
            end
            checks++;
            if (!$onehot0(grant) || ((grant != '0) && (!busy || xbar_sel !== grant))) begin
                errors++;
                $display("FAIL lock_credits_inv[%0d]: grant=%b busy=%b xbar_sel=%b, required one-hot/zero grant with busy and xbar_sel==grant",
                         i, grant, busy, xbar_sel);
            end
        end
    endtask

    task automatic test_tail_rotation();
        logic [W-1:0] obs, expv;
        rows.delete();
        rows.push_back(mk(5'b10001, 5'b00001, 1, 0, 5'b00000, 5'b00001, 1, 3'd0, 0));
        rows.push_back(mk(5'b10001, 5'b00001, 0, 0, 5'b00001, 5'b00001, 1, 3'd1, 0));
        rows.push_back(mk(5'b10001, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 3'd0, 0));
        rows.push_back(mk(5'b10001, 5'b10000, 1, 0, 5'b00000, 5'b10000, 1, 3'd0, 0));
        rows.push_back(mk(5'b10001, 5'b10000, 0, 0, 5'b10000, 5'b10000, 1, 3'd1, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 1, 0, 5'b00000, 5'b00000, 0, 3'd0, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 1, 0, 5'b00000, 5'b00000, 0, 3'd1, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 1, 0, 5'b00000, 5'b00000, 0, 3'd2, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 1, 0, 5'b00000, 5'b00000, 0, 3'd3, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 3'd4, 0));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            obs  = {grant, xbar_sel, busy, credits, credit_err};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL tail_rotation[%0d]: got %s, expected %s", i, fmt(obs), fmt(expv));
            end
            checks++;
            if (!$onehot0(grant) || ((grant != '0) && (!busy || xbar_sel !== grant))) begin
                errors++;
                $display("FAIL tail_rotation_inv[%0d]: grant=%b busy=%b xbar_sel=%b, required one-hot/zero grant with busy and xbar_sel==grant",
                         i, grant, busy, xbar_sel);
            end
        end
    endtask

    // All inputs request single-flit packets. A credit comes back in each grant
    // cycle, so the count stays at 4 and no saturation error is raised.
    task automatic test_single_flit_rr();
        logic [W-1:0]      obs, expv;
        logic [NPORTS-1:0] order [6];
        order = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        rows.delete();
        for (int k = 0; k < 6; k++) begin
            rows.push_back(mk(5'b11111, 5'b11111, 0, 0, 5'b00000, 5'b00000, 0, 3'd4, 0));
            rows.push_back(mk(5'b11111, 5'b11111, 1, 0, order[k], order[k], 1, 3'd4, 0));
        end
        foreach (rows[i]) begin
            apply_row(rows[i]);
            obs  = {grant, xbar_sel, busy, credits, credit_err};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL single_flit_rr[%0d]: got %s, expected %s", i, fmt(obs), fmt(expv));
            end
            checks++;
            if (!$onehot0(grant) || ((grant != '0) && (!busy || xbar_sel !== grant))) begin
                errors++;
                $display("FAIL single_flit_rr_inv[%0d]: grant=%b busy=%b xbar_sel=%b, required one-hot/zero grant with busy and xbar_sel==grant",
                         i, grant, busy, xbar_sel);
            end
        end
    endtask

    task automatic test_bubble();
        logic [W-1:0] obs, expv;
        rows.delete();
        rows.push_back(mk(5'b01010, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 3'd4, 0));
        rows.push_back(mk(5'b01010, 5'b00000, 0, 0, 5'b00010, 5'b00010, 1, 3'd4, 0));
        for (int k = 0; k < 3; k++) begin
            rows.push_back(mk(5'b01000, 5'b01000, 0, 0, 5'b00000, 5'b00010, 1, 3'd3, 0));
        end
        rows.push_back(mk(5'b01010, 5'b00010, 1, 0, 5'b00010, 5'b00010, 1, 3'd3, 0));
        rows.push_back(mk(5'b01000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 3'd3, 0));
        rows.push_back(mk(5'b01000, 5'b01000, 1, 0, 5'b01000, 5'b01000, 1, 3'd3, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 1, 0, 5'b00000, 5'b00000, 0, 3'd3, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 3'd4, 0));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            obs  = {grant, xbar_sel, busy, credits, credit_err};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL bubble[%0d]: got %s, expected %s", i, fmt(obs), fmt(expv));
            end
            checks++;
            if (!$onehot0(grant) || ((grant != '0) && (!busy || xbar_sel !== grant))) begin
                errors++;
                $display("FAIL bubble_inv[%0d]: grant=%b busy=%b xbar_sel=%b, required one-hot/zero grant with busy and xbar_sel==grant",
                         i, grant, busy, xbar_sel);
            end
        end
    endtask

    task automatic test_credit_err();
        logic [W-1:0] obs, expv;
        rows.delete();
        rows.push_back(mk(5'b00000, 5'b00000, 1, 0, 5'b00000, 5'b00000, 0, 3'd4, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 3'd4, 1));
        rows.push_back(mk(5'b00001, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 3'd4, 1));
        rows.push_back(mk(5'b00001, 5'b00001, 0, 0, 5'b00001, 5'b00001, 1, 3'd4, 1));
        rows.push_back(mk(5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 3'd3, 1));
        rows.push_back(mk(5'b00000, 5'b00000, 1, 0, 5'b00000, 5'b00000, 0, 3'd3, 1));
        rows.push_back(mk(5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 3'd4, 1));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            obs  = {grant, xbar_sel, busy, credits, credit_err};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL credit_err[%0d]: got %s, expected %s", i, fmt(obs), fmt(expv));
            end
            checks++;
            if (!$onehot0(grant) || ((grant != '0) && (!busy || xbar_sel !== grant))) begin
                errors++;
                $display("FAIL credit_err_inv[%0d]: grant=%b busy=%b xbar_sel=%b, required one-hot/zero grant with busy and xbar_sel==grant",
                         i, grant, busy, xbar_sel);
            end
        end
    endtask

    // Reset lands while W owns the output with one credit left and a credit pulse
    // in flight. The pulse must be dropped and the pointer must restart at N.
    task automatic test_reset_mid_packet();
        logic [W-1:0] obs, expv;
        rows.delete();
        rows.push_back(mk(5'b00100, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 3'd4, 1));
        rows.push_back(mk(5'b00100, 5'b00000, 0, 0, 5'b00100, 5'b00100, 1, 3'd4, 1));
        rows.push_back(mk(5'b00100, 5'b00000, 0, 0, 5'b00100, 5'b00100, 1, 3'd3, 1));
        rows.push_back(mk(5'b00100, 5'b00000, 0, 0, 5'b00100, 5'b00100, 1, 3'd2, 1));
        rows.push_back(mk(5'b00100, 5'b00000, 1, 1, 5'b00100, 5'b00100, 1, 3'd1, 1));
        rows.push_back(mk(5'b11111, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 3'd4, 0));
        rows.push_back(mk(5'b11111, 5'b00000, 0, 0, 5'b00001, 5'b00001, 1, 3'd4, 0));
        rows.push_back(mk(5'b11111, 5'b00001, 1, 0, 5'b00001, 5'b00001, 1, 3'd3, 0));
        rows.push_back(mk(5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 3'd3, 0));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            obs  = {grant, xbar_sel, busy, credits, credit_err};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_mid_packet[%0d]: got %s, expected %s", i, fmt(obs), fmt(expv));
            end
            checks++;
            if (!$onehot0(grant) || ((grant != '0) && (!busy || xbar_sel !== grant))) begin
                errors++;
                $display("FAIL reset_mid_packet_inv[%0d]: grant=%b busy=%b xbar_sel=%b, required one-hot/zero grant with busy and xbar_sel==grant",
                         i, grant, busy, xbar_sel);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_lock_and_credits();
        test_tail_rotation();
        test_single_flit_rr();
        test_bubble();
        test_credit_err();
        test_reset_mid_packet();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
